// File: rtl/traffic_time_regfile.sv
// Phase-duration register file: staged operator entry, range check, atomic commit to active times.
// Optional macro TIME_READBACK_EN adds a registered single-phase readback port (rd_idx / rd_time).
module traffic_time_regfile #(
  parameter int NUM_PHASES = 3,
  parameter int TIME_W     = 7,
  parameter int SHORT_IDX  = 1,
  parameter int MAX_LONG   = 99,
  parameter int MAX_SHORT  = 6,
  parameter int DEF_LONG   = 30,
  parameter int DEF_SHORT  = 3,
  localparam int IDX_W = $clog2(NUM_PHASES + 1),
  localparam int RD_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_mode,
  input  logic [TIME_W-1:0]            A,
  input  logic                         data_valid,
  output logic [NUM_PHASES*TIME_W-1:0] time_flat,
  output logic [NUM_PHASES-1:0]        alert_time,
  output logic [IDX_W-1:0]             entry_idx,
  output logic                         busy,
  output logic                         commit,
  output logic                         reject
`ifdef TIME_READBACK_EN
  ,
  input  logic [RD_W-1:0]              rd_idx,
  output logic [TIME_W-1:0]            rd_time
`endif
);

  typedef enum logic [1:0] {IDLE, ENTRY, CHECK, HOLD} state_t;

  state_t            state_q, state_d;
  logic [TIME_W-1:0] active_q [NUM_PHASES];
  logic [TIME_W-1:0] active_d [NUM_PHASES];
  logic [TIME_W-1:0] shadow_q [NUM_PHASES];
  logic [TIME_W-1:0] shadow_d [NUM_PHASES];
  logic [IDX_W-1:0]  entry_idx_q, entry_idx_d;
  logic              commit_q, commit_d;
  logic              reject_q, reject_d;

  function automatic logic [TIME_W-1:0] default_time(input int i);
    return (i == SHORT_IDX) ? TIME_W'(DEF_SHORT) : TIME_W'(DEF_LONG);
  endfunction

  function automatic logic is_invalid(input logic [TIME_W-1:0] v, input int i);
    logic [TIME_W-1:0] lim;
    lim = (i == SHORT_IDX) ? TIME_W'(MAX_SHORT) : TIME_W'(MAX_LONG);
    return (v == '0) || (v > lim);
  endfunction

  always_comb begin
    alert_time = '0;
    time_flat  = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      alert_time[i]                  = is_invalid(shadow_q[i], i);
      time_flat[i*TIME_W +: TIME_W]  = active_q[i];
    end
  end

  assign entry_idx = entry_idx_q;
  assign busy      = (state_q != IDLE);
  assign commit    = commit_q;
  assign reject    = reject_q;

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    shadow_d    = shadow_q;
    entry_idx_d = entry_idx_q;
    commit_d    = 1'b0;
    reject_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (set_mode) begin
          state_d     = ENTRY;
          entry_idx_d = '0;
          for (int i = 0; i < NUM_PHASES; i++) shadow_d[i] = '0;
        end
      end
      ENTRY: begin
        // Dropping set_mode aborts the session even if a strobe arrives on the same edge.
        if (!set_mode) begin
          state_d = IDLE;
        end else if (data_valid && (entry_idx_q < IDX_W'(NUM_PHASES))) begin
          for (int i = 0; i < NUM_PHASES; i++)
            if (entry_idx_q == IDX_W'(i)) shadow_d[i] = A;
          entry_idx_d = entry_idx_q + IDX_W'(1);
          if (entry_idx_q == IDX_W'(NUM_PHASES - 1)) state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = HOLD;
        if (alert_time == '0) begin
          active_d = shadow_q;
          commit_d = 1'b1;
        end else begin
          reject_d = 1'b1;
        end
      end
      HOLD: begin
        if (!set_mode) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      entry_idx_q <= '0;
      commit_q    <= 1'b0;
      reject_q    <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
        active_q[i] <= default_time(i);
        shadow_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      entry_idx_q <= entry_idx_d;
      commit_q    <= commit_d;
      reject_q    <= reject_d;
      active_q    <= active_d;
      shadow_q    <= shadow_d;
    end
  end

`ifdef TIME_READBACK_EN
  logic [TIME_W-1:0] rd_time_q, rd_time_d;

  // Out-of-range indices match no phase and read back as zero.
  always_comb begin
    rd_time_d = '0;
    for (int i = 0; i < NUM_PHASES; i++)
      if (rd_idx == RD_W'(i)) rd_time_d = active_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_time_q <= '0;
    else     rd_time_q <= rd_time_d;
  end

  assign rd_time = rd_time_q;
`endif

endmodule

// File: tb/tb_traffic_time_regfile.sv
// Directed bench for traffic_time_regfile: session-level expectation model checked every cycle,
// plus literal spot checks. Define TIME_READBACK_EN to also exercise the readback port.
module tb_traffic_time_regfile;

  logic        clk;
  logic        rst;
  logic        set_mode;
  logic [6:0]  A;
  logic        data_valid;
  logic [20:0] time_flat;
  logic [2:0]  alert_time;
  logic [1:0]  entry_idx;
  logic        busy;
  logic        commit;
  logic        reject;
`ifdef TIME_READBACK_EN
  logic [1:0]  rd_idx;
  logic [6:0]  rd_time;
`endif

  traffic_time_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .set_mode   (set_mode),
    .A          (A),
    .data_valid (data_valid),
    .time_flat  (time_flat),
    .alert_time (alert_time),
    .entry_idx  (entry_idx),
    .busy       (busy),
    .commit     (commit),
    .reject     (reject)
`ifdef TIME_READBACK_EN
    ,
    .rd_idx     (rd_idx),
    .rd_time    (rd_time)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Expected architectural state, updated by the session tasks from the protocol rules.
  int exp_active [3];
  int exp_shadow [3];
  int exp_idx;
  bit exp_busy, exp_commit, exp_reject;

  function automatic bit bad(input int v, input int i);
    int lim;
    lim = (i == 1) ? 6 : 99;
    return (v == 0) || (v > lim);
  endfunction

  function automatic logic [2:0] model_alert();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = bad(exp_shadow[i], i);
    return r;
  endfunction

  function automatic logic [20:0] model_flat();
    logic [20:0] r;
    for (int i = 0; i < 3; i++) r[i*7 +: 7] = 7'(exp_active[i]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("time_flat",  64'(time_flat),  64'(model_flat()));
      check("alert_time", 64'(alert_time), 64'(model_alert()));
      check("entry_idx",  64'(entry_idx),  64'(exp_idx));
      check("busy",       64'(busy),       64'(exp_busy));
      check("commit",     64'(commit),     64'(exp_commit));
      check("reject",     64'(reject),     64'(exp_reject));
    end
  end

  task automatic step(input bit r, input bit sm, input bit dv, input int a);
    rst        = r;
    set_mode   = sm;
    data_valid = dv;
    A          = 7'(a);
    @(posedge clk);
    #1;
    exp_commit = 0;
    exp_reject = 0;
  endtask

  task automatic do_reset(input bit sm);
    step(1, sm, 0, 0);
    exp_active = '{30, 3, 30};
    exp_shadow = '{0, 0, 0};
    exp_idx    = 0;
    exp_busy   = 0;
  endtask

  // Opens a session, strobes n values, then either aborts (n < 3) or walks check/hold/close.
  task automatic session(input int v0, input int v1, input int v2, input int n);
    int v [3];
    bit ok;
    v = '{v0, v1, v2};
    step(0, 1, 0, 0);
    exp_busy = 1; exp_idx = 0; exp_shadow = '{0, 0, 0};
    for (int k = 0; k < n; k++) begin
      step(0, 1, 1, v[k]);
      exp_shadow[k] = v[k];
      exp_idx       = k + 1;
    end
    if (n < 3) begin
      step(0, 0, 0, 0);
      exp_busy = 0;
      return;
    end
    step(0, 1, 0, 0);
    ok = 1;
    for (int k = 0; k < 3; k++) if (bad(v[k], k)) ok = 0;
    if (ok) begin
      exp_active = v;
      exp_commit = 1;
    end else begin
      exp_reject = 1;
    end
    step(0, 1, 1, 9);
    step(0, 0, 0, 0);
    exp_busy = 0;
  endtask

  initial begin
    rst = 1; set_mode = 0; data_valid = 0; A = '0;
`ifdef TIME_READBACK_EN
    rd_idx = 2'd0;
`endif
    do_reset(0);
    do_reset(0);
    chk_en = 1;
    step(0, 0, 0, 0);

    check("rst_flat",   64'(time_flat),  64'({7'd30, 7'd3, 7'd30}));
    check("rst_alert",  64'(alert_time), 64'(3'b111));
    check("rst_busy",   64'(busy),       64'd0);
    check("rst_commit", 64'(commit),     64'd0);
`ifdef TIME_READBACK_EN
    check("rst_rd_time", 64'(rd_time), 64'd0);
`endif

    session(20, 7, 50, 3);
    check("rej_yel_alert", 64'(alert_time), 64'(3'b010));
    check("rej_yel_flat",  64'(time_flat),  64'({7'd30, 7'd3, 7'd30}));
    session(0, 4, 60, 3);
    check("rej_zero_alert", 64'(alert_time), 64'(3'b001));
    session(45, 4, 100, 3);
    check("rej_100_alert", 64'(alert_time), 64'(3'b100));
    check("rej_100_flat",  64'(time_flat),  64'({7'd30, 7'd3, 7'd30}));

    session(45, 4, 60, 3);
    check("cmt_flat",  64'(time_flat),  64'({7'd60, 7'd4, 7'd45}));
    check("cmt_alert", 64'(alert_time), 64'(3'b000));
`ifdef TIME_READBACK_EN
    rd_idx = 2'd1;
    step(0, 0, 0, 0);
    check("rd_yellow", 64'(rd_time), 64'd4);
    rd_idx = 2'd3;
    step(0, 0, 0, 0);
    check("rd_oob", 64'(rd_time), 64'd0);
    rd_idx = 2'd2;
    step(0, 0, 0, 0);
    check("rd_red", 64'(rd_time), 64'd60);
`endif

    session(10, 2, 10, 2);
    check("abort_idx",  64'(entry_idx), 64'd2);
    check("abort_flat", 64'(time_flat), 64'({7'd60, 7'd4, 7'd45}));

    // Abort and strobe on the same edge: the write must be dropped.
    step(0, 1, 0, 0);
    exp_busy = 1; exp_idx = 0; exp_shadow = '{0, 0, 0};
    step(0, 1, 1, 11);
    exp_shadow[0] = 11; exp_idx = 1;
    step(0, 0, 1, 12);
    exp_busy = 0;
    check("abort_drop_idx", 64'(entry_idx), 64'd1);

    // Reset in the middle of an entry session.
    step(0, 1, 0, 0);
    exp_busy = 1; exp_idx = 0; exp_shadow = '{0, 0, 0};
    step(0, 1, 1, 5);
    exp_shadow[0] = 5; exp_idx = 1;
    step(0, 1, 1, 5);
    exp_shadow[1] = 5; exp_idx = 2;
    do_reset(0);
    check("midrst_flat",  64'(time_flat),  64'({7'd30, 7'd3, 7'd30}));
    check("midrst_busy",  64'(busy),       64'd0);
    check("midrst_alert", 64'(alert_time), 64'(3'b111));
    step(0, 0, 0, 0);

    session(25, 5, 99, 3);
    check("edge99_flat", 64'(time_flat), 64'({7'd99, 7'd5, 7'd25}));
    session(1, 6, 1, 3);
    check("edge6_flat", 64'(time_flat), 64'({7'd1, 7'd6, 7'd1}));
    session(50, 6, 1, 2);
    check("reopen_idx", 64'(entry_idx), 64'd2);

    step(0, 0, 0, 0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_time_regfile.md
Name: traffic_time_regfile

Overview:
Parametrised phase-duration register file for the traffic light controller. It stages operator-entered phase times into shadow registers and range-checks every entry. Only a complete, fully valid set is committed atomically to the active registers read by the phase sequencer. It generalises the fixed 3-phase, 7-bit time register to N phases, with a staged-entry FSM, commit/abort and per-phase limits.

Parameters:
NUM_PHASES, 3, number of phase times (index 0 = green, 1 = yellow, 2 = red, further = extra phases)
TIME_W, 7, bit width of each time value
SHORT_IDX, 1, index of the phase that uses the short limit (yellow)
MAX_LONG, 99, inclusive upper limit for all phases except SHORT_IDX
MAX_SHORT, 6, inclusive upper limit for phase SHORT_IDX
DEF_LONG, 30, reset value of active long phases
DEF_SHORT, 3, reset value of active phase SHORT_IDX

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
set_mode  in  1  level; high = entry session open
A  in  TIME_W  time value to enter
data_valid  in  1  one-cycle strobe; A is captured when high in ENTRY
time_flat  out  NUM_PHASES*TIME_W  active times; phase i at bits [i*TIME_W +: TIME_W]
alert_time  out  NUM_PHASES  per-shadow-entry invalid flag
entry_idx  out  clog2(NUM_PHASES+1)  next shadow index to be written
busy  out  1  high while FSM not IDLE
commit  out  1  one-cycle pulse when active registers are updated
reject  out  1  one-cycle pulse when a complete set fails the check

Behaviour:
- Reset (rst high at a clk edge), applied from any state including mid-entry:
  - active[SHORT_IDX] = DEF_SHORT; all other active = DEF_LONG
  - shadow all 0, entry_idx = 0, FSM = IDLE
  - commit = 0, reject = 0, busy = 0
- Entry is defined as invalid when value == 0 or value > limit, where limit is MAX_SHORT for SHORT_IDX and MAX_LONG otherwise. Comparisons are unsigned at TIME_W bits.
- alert_time[i] = invalid(shadow[i]); combinational from registered shadow. After reset it is all-ones, because shadow is 0.
- FSM states: IDLE, ENTRY, CHECK, HOLD.
  - IDLE: set_mode = 1 -> ENTRY; on the same edge, clear shadow to 0 and set entry_idx = 0.
  - ENTRY: data_valid = 1 -> shadow[entry_idx] <= A, entry_idx + 1. When the write fills index NUM_PHASES-1 -> CHECK next cycle.
  - ENTRY: set_mode = 0 before the set is full -> abort to IDLE. Active is unchanged and neither commit nor reject pulses.
  - ENTRY: data_valid and set_mode falling on the same edge -> the abort wins and the write is dropped.
  - CHECK (one cycle): if no bit of alert_time is set, copy all shadow to active on this edge and pulse commit; else pulse reject and leave active unchanged. Go to HOLD in both cases.
  - HOLD: ignore data_valid. set_mode = 0 -> IDLE. A new session needs set_mode low for at least one cycle, then high again.
- Latency: the last data_valid edge -> CHECK next cycle -> time_flat updates and commit is high on the edge after that. Total is 2 cycles from the final strobe to new time_flat.
- time_flat never shows a partial set; all phases change on the same edge.
- busy = (state != IDLE).
- entry_idx saturates at NUM_PHASES; extra data_valid strobes are ignored.

Optional Feature:
TIME_READBACK_EN
- Defined: adds input rd_idx (clog2(NUM_PHASES) bits) and output rd_time (TIME_W bits).
  - rd_time is registered and equals active[rd_idx] one cycle after rd_idx is presented.
  - rd_time is 0 after reset. An out-of-range rd_idx returns 0.
- Undefined: neither port exists and no readback logic is built; all other behaviour is identical.

Test Plan:
- Reset -> time_flat phases = {30, 3, 30}, alert_time = 3'b111, busy = 0, commit = 0.
- set_mode = 1; strobe A = 45, 4, 60; hold set_mode -> commit pulses 2 cycles after the last strobe; time_flat = {45, 4, 60}; alert_time = 0.
- Session with A = 20, 7, 50 (yellow > 6) -> reject pulses, alert_time = 3'b010, time_flat still {30, 3, 30}.
- Session with A = 0 or A = 100 in a long phase -> reject, corresponding alert bit set, active unchanged.
- Strobe 2 of 3 values, then drop set_mode -> back to IDLE, no commit or reject, active unchanged; a new session starts at entry_idx = 0.
- Assert rst during ENTRY after 2 strobes -> defaults restored and IDLE next cycle. With TIME_READBACK_EN, rd_idx = 1 after a commit of {45, 4, 60} -> rd_time = 4 one cycle later.
